// File: rtl/ram_dma_ctrl_if.sv
// ram_dma_ctrl_if: shared-bus request/grant and address/write-enable channel
// between the DMA controller (master) and the bus arbiter (slave).
//   bus_req  : master -> arbiter, bus request
//   bus_gnt  : arbiter -> master, bus grant
//   bus_addr : master address, muxed onto the shared bus when granted
//   bus_we   : master write enable
interface ram_dma_ctrl_if;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] bus_addr;
    logic       bus_we;

    modport master (output bus_req, output bus_addr, output bus_we, input bus_gnt);
    modport slave  (input bus_req, input bus_addr, input bus_we, output bus_gnt);
endinterface

// File: rtl/ram_dma_ctrl.sv
// ram_dma_ctrl: second bus master performing block copy / block fill on the
// 8-bit shared bus, yielding the bus after every MAX_BURST bytes.
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_start          : one-cycle transfer request (ignored unless idle)
//   i_mode           : 0 = copy src->dst, 1 = fill dst with i_fill_data
//   i_src_addr, i_dst_addr, i_len, i_fill_data : transfer config, latched on start
//   bus              : request/grant, address and write enable to the arbiter
//   io_bus_data      : shared data bus, driven only while writing
//   o_busy, o_done   : transfer in progress, one-cycle completion pulse
module ram_dma_ctrl #(
    parameter logic [7:0]  PARK_ADDR = 8'hFF,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic [7:0]           i_src_addr,
    input  logic [7:0]           i_dst_addr,
    input  logic [7:0]           i_len,
    input  logic [7:0]           i_fill_data,
    ram_dma_ctrl_if.master       bus,
    inout  wire  [7:0]           io_bus_data,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_CAP, S_WR, S_FILL, S_YIELD
    } state_t;

    state_t     r_state, w_nxt_state;
    logic       r_mode, w_nxt_mode;
    logic [7:0] r_src, w_nxt_src;
    logic [7:0] r_dst, w_nxt_dst;
    logic [7:0] r_rem, w_nxt_rem;
    logic [7:0] r_burst, w_nxt_burst;
    logic [7:0] r_fill, w_nxt_fill;
    logic [7:0] r_data;
    logic       r_req, w_nxt_req;
    logic [7:0] r_addr, w_nxt_addr;
    logic       r_we, w_nxt_we;
    logic       r_busy, w_nxt_busy;
    logic       r_done, w_nxt_done;

    // Next-state, counters, and bus outputs decoded from the next state so they register in step
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mode  = r_mode;
        w_nxt_src   = r_src;
        w_nxt_dst   = r_dst;
        w_nxt_rem   = r_rem;
        w_nxt_burst = r_burst;
        w_nxt_fill  = r_fill;
        w_nxt_done  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != 8'd0) begin
                        w_nxt_mode  = i_mode;
                        w_nxt_src   = i_src_addr;
                        w_nxt_dst   = i_dst_addr;
                        w_nxt_rem   = i_len;
                        w_nxt_fill  = i_fill_data;
                        w_nxt_burst = 8'd0;
                        w_nxt_state = S_REQ;
                    end else begin
                        w_nxt_done  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus.bus_gnt) begin
                    w_nxt_state = r_mode ? S_FILL : S_RD;
                end
            end
            S_RD:  w_nxt_state = S_CAP;
            S_CAP: w_nxt_state = S_WR;
            S_WR, S_FILL: begin
                // A byte completes in every WR/FILL cycle
                w_nxt_src = r_src + 8'd1;
                w_nxt_dst = r_dst + 8'd1;
                w_nxt_rem = r_rem - 8'd1;
                if (r_rem == 8'd1) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_burst = 8'd0;
                    w_nxt_state = S_IDLE;
                end else if (r_burst + 8'd1 == LP_MAX_BURST) begin
                    w_nxt_burst = 8'd0;
                    w_nxt_state = S_YIELD;
                end else begin
                    w_nxt_burst = r_burst + 8'd1;
                    w_nxt_state = (r_state == S_FILL) ? S_FILL : S_RD;
                end
            end
            S_YIELD: w_nxt_state = S_REQ;
            default: w_nxt_state = S_IDLE;
        endcase

        w_nxt_req  = 1'b0;
        w_nxt_we   = 1'b0;
        w_nxt_addr = PARK_ADDR;
        unique case (w_nxt_state)
            S_REQ, S_CAP: w_nxt_req = 1'b1;
            S_RD: begin
                w_nxt_req  = 1'b1;
                w_nxt_addr = w_nxt_src;
            end
            S_WR, S_FILL: begin
                w_nxt_req  = 1'b1;
                w_nxt_we   = 1'b1;
                w_nxt_addr = w_nxt_dst;
            end
            default: w_nxt_req = 1'b0;
        endcase
        w_nxt_busy = (w_nxt_state != S_IDLE);
    end

    // State, config and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_src   <= 8'd0;
            r_dst   <= 8'd0;
            r_rem   <= 8'd0;
            r_burst <= 8'd0;
            r_fill  <= 8'd0;
            r_data  <= 8'd0;
            r_req   <= 1'b0;
            r_addr  <= PARK_ADDR;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_mode  <= w_nxt_mode;
            r_src   <= w_nxt_src;
            r_dst   <= w_nxt_dst;
            r_rem   <= w_nxt_rem;
            r_burst <= w_nxt_burst;
            r_fill  <= w_nxt_fill;
            r_req   <= w_nxt_req;
            r_addr  <= w_nxt_addr;
            r_we    <= w_nxt_we;
            r_busy  <= w_nxt_busy;
            r_done  <= w_nxt_done;
            // RAM presents Mem[src] during CAP (registered read)
            if (r_state == S_CAP) begin
                r_data <= io_bus_data;
            end
        end
    end

    assign io_bus_data = (r_state == S_WR)   ? r_data :
                         (r_state == S_FILL) ? r_fill : 8'bzzzz_zzzz;

    assign bus.bus_req  = r_req;
    assign bus.bus_addr = r_addr;
    assign bus.bus_we   = r_we;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_ram_dma_ctrl.sv
// tb_ram_dma_ctrl: self-checking bench for ram_dma_ctrl with a 128-byte
// registered-read RAM, a simple arbiter and a transfer-level reference model.
module tb_ram_dma_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, mode;
    logic [7:0] src, dst, len, fill;
    logic       busy, done;
    wire  [7:0] bus_data;
    logic [7:0] ram_q;
    logic       ram_oe;

    ram_dma_ctrl_if bif ();

    ram_dma_ctrl #(.PARK_ADDR(8'hFF), .MAX_BURST(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
        .i_src_addr(src), .i_dst_addr(dst), .i_len(len), .i_fill_data(fill),
        .bus(bif.master), .io_bus_data(bus_data), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    assign bus_data = ram_oe ? ram_q : 8'bzzzz_zzzz;

    // Arbiter: manual grant, or automatic grant after a random delay
    logic auto_arb, man_gnt, arb_gnt;
    int   arb_wait, arb_delay;
    assign bif.bus_gnt = auto_arb ? arb_gnt : man_gnt;
    always @(posedge clk) begin
        if (!bif.bus_req) begin
            arb_gnt   <= 1'b0;
            arb_wait  <= 0;
            arb_delay <= int'($urandom_range(0, 3));
        end else if (!arb_gnt) begin
            if (arb_wait >= arb_delay) arb_gnt <= 1'b1;
            else arb_wait <= arb_wait + 1;
        end
    end

    // RAM: 0x00..0x7F, registered read; backdoor preload port
    logic [7:0] mem [0:127];
    logic       pl_en;
    logic [6:0] pl_addr;
    logic [7:0] pl_data;
    wire        bus_we_m   = bif.bus_gnt & bif.bus_we;
    wire  [7:0] bus_addr_m = bif.bus_gnt ? bif.bus_addr : 8'hFF;
    always @(posedge clk) begin
        ram_oe <= 1'b0;
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus_we_m && bus_addr_m < 8'h80) mem[bus_addr_m[6:0]] <= bus_data;
        if (!pl_en && !bus_we_m && bus_addr_m < 8'h80) begin
            ram_q  <= mem[bus_addr_m[6:0]];
            ram_oe <= 1'b1;
        end
    end

    // Bus monitors: write log, contention, yield cycles, request cycles
    logic [15:0] wlog [0:4095];
    int wcnt = 0, contention = 0, yield_cyc = 0, req_cyc = 0;
    always @(posedge clk) begin
        if (bus_we_m && wcnt < 4096) begin
            wlog[wcnt] <= {bus_addr_m, bus_data};
            wcnt       <= wcnt + 1;
        end
    end
    always @(negedge clk) begin
        if (ram_oe && bif.bus_we) contention <= contention + 1;
        if (busy && !bif.bus_req) yield_cyc <= yield_cyc + 1;
        if (bif.bus_req)          req_cyc   <= req_cyc + 1;
    end

    int n_checks = 0, n_errors = 0;
    logic [7:0] exp_mem [0:127];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Load RAM and the model with random contents
    task automatic preload();
        pl_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            exp_mem[i] = 8'($urandom);
            pl_addr    = 7'(i);
            pl_data    = exp_mem[i];
            @(posedge clk);
            @(negedge clk);
        end
        pl_en = 1'b0;
    endtask

    // kind: 0 plain, 1 second START mid-transfer, 2 grant held low 5 cycles
    task automatic run_xfer(input string tag, input logic m, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] l, input logic [7:0] f,
                            input int kind, input int exp_lat, input int exp_yield,
                            input int exp_req);
        logic [15:0] expw [$];
        logic [7:0]  a, v;
        int w0, c0, y0, r0, n, bad, early_we;
        for (int i = 0; i < int'(l); i++) begin
            a = 8'(int'(d) + i);
            v = m ? f : exp_mem[7'(int'(s) + i)];
            if (a < 8'h80) exp_mem[a[6:0]] = v;
            expw.push_back({a, v});
        end
        w0 = wcnt; c0 = contention; y0 = yield_cyc; r0 = req_cyc;
        @(negedge clk);
        if (kind == 2) man_gnt = 1'b0;
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill = f;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src = ~s; dst = ~d; len = 8'd5; fill = ~f; mode = ~m;
        n = 0; early_we = 0;
        while (!done && n < 3000) begin
            if (kind == 1) start = (n == 4);
            if (kind == 2) begin
                if (n < 5 && bif.bus_we) early_we++;
                if (n == 5) man_gnt = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 3000) check_eq({tag, "_timeout"}, n, 0);
        if (exp_lat >= 0) check_eq({tag, "_latency"}, n, exp_lat);
        if (kind == 2) check_eq({tag, "_we_before_gnt"}, early_we, 0);
        check_eq({tag, "_busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        check_eq({tag, "_done_width"}, int'(done), 0);
        check_eq({tag, "_nwrites"}, wcnt - w0, expw.size());
        for (int i = 0; i < expw.size() && i < wcnt - w0; i++)
            check_eq($sformatf("%s_write%0d", tag, i), int'(wlog[w0 + i]), int'(expw[i]));
        check_eq({tag, "_contention"}, contention - c0, 0);
        if (exp_yield >= 0) check_eq({tag, "_yields"}, yield_cyc - y0, exp_yield);
        if (exp_req >= 0) check_eq({tag, "_req_cycles"}, req_cyc - r0, exp_req);
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) bad++;
        check_eq({tag, "_mem"}, bad, 0);
    endtask

    initial begin
        int l, b, s, d;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
        auto_arb = 1'b0; man_gnt = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", int'(bif.bus_req), 0);
        check_eq("rst_addr", int'(bif.bus_addr), 8'hFF);
        check_eq("rst_we", int'(bif.bus_we), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        rst_n = 1'b1;

        // Directed copy: 4 bytes, constant grant, DONE 13 edges after START
        preload();
        exp_mem[8'h10] = 8'hA1; exp_mem[8'h11] = 8'hB2; exp_mem[8'h12] = 8'hC3; exp_mem[8'h13] = 8'hD4;
        pl_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pl_addr = 7'(8'h10 + i); pl_data = exp_mem[7'(8'h10 + i)];
            @(posedge clk); @(negedge clk);
        end
        pl_en = 1'b0;
        run_xfer("copy4", 1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 0, 13, 0, -1);

        // Fill 20 bytes with two forced yields; 0x34 stays 0
        exp_mem[8'h34] = 8'h00;
        pl_en = 1'b1; pl_addr = 7'h34; pl_data = 8'h00;
        @(posedge clk); @(negedge clk);
        pl_en = 1'b0;
        run_xfer("fill20", 1'b1, 8'h00, 8'h20, 8'd20, 8'h5A, 0, 20 + 3 + 2, 2, -1);

        run_xfer("gnt_delay", 1'b0, 8'h05, 8'h70, 8'd3, 8'h00, 2, -1, 0, -1);
        run_xfer("len0", 1'b0, 8'h00, 8'h00, 8'd0, 8'h00, 0, 0, 0, 0);
        run_xfer("wrap", 1'b1, 8'h00, 8'hFE, 8'd3, 8'h3C, 0, 3 + 1, 0, -1);
        run_xfer("restart", 1'b0, 8'h20, 8'h50, 8'd6, 8'h00, 1, 6 * 3 + 1, 0, -1);

        // Reset mid-transfer: outputs return to idle, no DONE pulse
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src = 8'h30; dst = 8'h60; len = 8'd6;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_req", int'(bif.bus_req), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_we", int'(bif.bus_we), 0);
        rst_n = 1'b1;
        preload();
        run_xfer("after_rst", 1'b0, 8'h00, 8'h40, 8'd10, 8'h00, 0, 30 + 2 + 1, 1, -1);

        // Randomized transfers with a random-latency arbiter
        auto_arb = 1'b1;
        for (int t = 0; t < 10; t++) begin
            l = int'($urandom_range(1, 40));
            b = (l + 7) / 8;
            s = int'($urandom_range(0, 128 - l));
            d = int'($urandom_range(0, 128 - l));
            run_xfer($sformatf("rnd%0d", t), 1'($urandom), 8'(s), 8'(d), 8'(l),
                     8'($urandom), 0, -1, b - 1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
